// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF output latch, branch/jump redirect with
// wrong-path flush, stall hold, and fetch suppression once the PC leaves the ROM.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] pc,
    input  logic [31:0] instruction,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    // Bounds kept 33 bits wide so a ROM ending exactly at 2^32 does not wrap.
    localparam logic [32:0] ROM_LO = {1'b0, RESET_PC};
    localparam logic [32:0] ROM_HI = {1'b0, RESET_PC} + (33'(ROM_WORDS) * 33'd4);

    typedef enum logic [2:0] {
        ACT_JUMP   = 3'd0,
        ACT_BRANCH = 3'd1,
        ACT_STALL  = 3'd2,
        ACT_HALT   = 3'd3,
        ACT_FETCH  = 3'd4
    } action_e;

    logic [31:0] pc_r;
    logic [31:0] if_instr_r;
    logic [31:0] if_pc_plus4_r;
    logic        if_valid_r;
    logic [15:0] fetch_count_r;

    logic [31:0] pc_s;
    logic [31:0] if_instr_s;
    logic [31:0] if_pc_plus4_s;
    logic        if_valid_s;
    logic [15:0] fetch_count_s;

    logic [31:0] pc_plus4_s;
    logic [31:0] branch_target_s;
    logic [31:0] jump_target_s;
    logic        halted_s;
    action_e     action_s;

    // Target arithmetic and ROM range test.
    always_comb begin
        pc_plus4_s      = pc_r + 32'd4;
        branch_target_s = if_pc_plus4_r + {{14{branch_offset[15]}}, branch_offset, 2'b00};
        jump_target_s   = {if_pc_plus4_r[31:28], jump_target, 2'b00};
        halted_s        = ({1'b0, pc_r} < ROM_LO) || ({1'b0, pc_r} >= ROM_HI);
    end

    // Priority select: a redirect needs a real instruction in IF and beats stall and halt.
    always_comb begin
        action_s = ACT_FETCH;
        if (if_valid_r && jump) begin
            action_s = ACT_JUMP;
        end else if (if_valid_r && branch_taken) begin
            action_s = ACT_BRANCH;
        end else if (stall) begin
            action_s = ACT_STALL;
        end else if (halted_s) begin
            action_s = ACT_HALT;
        end else begin
            action_s = ACT_FETCH;
        end
    end

    // Next-state for PC and IF latch; every path starts from "hold".
    always_comb begin
        pc_s          = pc_r;
        if_instr_s    = if_instr_r;
        if_pc_plus4_s = if_pc_plus4_r;
        if_valid_s    = if_valid_r;
        fetch_count_s = fetch_count_r;
        case (action_s)
            ACT_JUMP: begin
                pc_s       = jump_target_s;
                if_instr_s = 32'h0000_0000;
                if_valid_s = 1'b0;
            end
            ACT_BRANCH: begin
                pc_s       = branch_target_s;
                if_instr_s = 32'h0000_0000;
                if_valid_s = 1'b0;
            end
            ACT_STALL: begin
                pc_s = pc_r;
            end
            ACT_HALT: begin
                if_instr_s = 32'h0000_0000;
                if_valid_s = 1'b0;
            end
            ACT_FETCH: begin
                pc_s          = pc_plus4_s;
                if_instr_s    = instruction;
                if_pc_plus4_s = pc_plus4_s;
                if_valid_s    = 1'b1;
                if (fetch_count_r != 16'hFFFF) begin
                    fetch_count_s = fetch_count_r + 16'd1;
                end else begin
                    fetch_count_s = fetch_count_r;
                end
            end
            default: begin
                pc_s       = pc_r;
                if_valid_s = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            if_instr_r    <= 32'h0000_0000;
            if_pc_plus4_r <= 32'h0000_0000;
            if_valid_r    <= 1'b0;
            fetch_count_r <= 16'h0000;
        end else begin
            pc_r          <= pc_s;
            if_instr_r    <= if_instr_s;
            if_pc_plus4_r <= if_pc_plus4_s;
            if_valid_r    <= if_valid_s;
            fetch_count_r <= fetch_count_s;
        end
    end

    assign pc          = pc_r;
    assign if_instr    = if_instr_r;
    assign if_pc_plus4 = if_pc_plus4_r;
    assign if_valid    = if_valid_r;
    assign halted      = halted_s;
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a driver pushes the model's expected post-edge
// state per cycle, a monitor pops and compares it after every rising edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken, jump;
    logic [15:0] branch_offset;
    logic [25:0] jump_target;
    logic [31:0] pc, instruction, if_instr, if_pc_plus4;
    logic        if_valid, halted;
    logic [15:0] fetch_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] p4;
        logic        valid;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem[16];

    logic [31:0] m_pc, m_instr, m_p4;
    logic        m_valid;
    logic [15:0] m_cnt;

    fetch_stage #(.RESET_PC(32'h0000_0000), .ROM_WORDS(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
        .pc(pc), .instruction(instruction), .if_instr(if_instr),
        .if_pc_plus4(if_pc_plus4), .if_valid(if_valid), .halted(halted),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a < 32'd64) return mem[a[5:2]];
        return {16'hBAD0, a[15:0]};
    endfunction

    assign instruction = imem(pc);

    function automatic logic out_of_rom(input logic [31:0] a);
        return a >= 32'd64;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one edge of the fetch stage expressed directly from the rules.
    task automatic drive(input logic r, input logic s, input logic bt, input logic [15:0] bo,
                         input logic j, input logic [25:0] jt);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; branch_taken = bt; branch_offset = bo; jump = j; jump_target = jt;
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0; m_cnt = 16'h0;
        end else if (m_valid && (j || bt)) begin
            if (j) m_pc = {m_p4[31:28], jt, 2'b00};
            else   m_pc = m_p4 + 32'($signed(bo)) * 32'd4;
            m_instr = 32'h0; m_valid = 1'b0;
        end else if (s) begin
            m_valid = m_valid;
        end else if (out_of_rom(m_pc)) begin
            m_instr = 32'h0; m_valid = 1'b0;
        end else begin
            m_instr = imem(m_pc);
            m_pc    = m_pc + 32'd4;
            m_p4    = m_pc;
            m_valid = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        e.pc = m_pc; e.instr = m_instr; e.p4 = m_p4; e.valid = m_valid;
        e.halted = out_of_rom(m_pc); e.cnt = m_cnt;
        q.push_back(e);
    endtask

    task automatic nrm();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    endtask

    task automatic peek();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare the DUT against the oldest pending expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("pc", pc, e.pc);
                cmp("if_instr", if_instr, e.instr);
                cmp("if_pc_plus4", if_pc_plus4, e.p4);
                cmp("if_valid", {31'h0, if_valid}, {31'h0, e.valid});
                cmp("halted", {31'h0, halted}, {31'h0, e.halted});
                cmp("fetch_count", {16'h0, fetch_count}, {16'h0, e.cnt});
            end
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_offset = 16'h0; jump_target = 26'h0;
        m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0; m_cnt = 16'h0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[0] = 32'h0022_1820; mem[1] = 32'hAC01_0000; mem[2] = 32'h8C24_0000;

        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
        peek();
        cmp("reset_pc", pc, 32'h0);
        cmp("reset_valid", {31'h0, if_valid}, 32'h0);

        // Sequential fetch
        nrm(); nrm(); nrm();
        peek();
        cmp("seq_pc", pc, 32'hC);
        cmp("seq_instr", if_instr, 32'h8C24_0000);
        cmp("seq_count", {16'h0, fetch_count}, 32'd3);

        // Forward and backward branch, jump-vs-branch conflict
        nrm();
        drive(1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 26'h0);
        peek();
        cmp("br_fwd_pc", pc, 32'h14);
        cmp("br_bubble", {31'h0, if_valid}, 32'h0);
        nrm();
        peek();
        cmp("br_target_instr", if_instr, mem[5]);
        drive(1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 26'h3);
        peek();
        cmp("jump_wins_pc", pc, 32'hC);
        nrm();
        drive(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0);
        peek();
        cmp("br_back_pc", pc, 32'h8);

        // Stall, redirect through stall, redirect ignored while IF empty
        nrm();
        drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
        drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
        drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
        drive(1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 26'h0);
        peek();
        cmp("stall_redirect_pc", pc, 32'h14);
        drive(1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 26'h0);
        peek();
        cmp("ignored_br_pc", pc, 32'h18);

        // Halt at ROM end, stays frozen
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
        repeat (16) nrm();
        peek();
        cmp("halt_pc", pc, 32'h40);
        cmp("halt_flag", {31'h0, halted}, 32'h1);
        nrm();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'h0);
        nrm();
        peek();
        cmp("halt_stuck_pc", pc, 32'h40);
        cmp("halt_count", {16'h0, fetch_count}, 32'd16);

        // Jump out of halt while the last ROM word is still valid
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
        repeat (16) nrm();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'h0);
        peek();
        cmp("unhalt_pc", pc, 32'h0);
        cmp("unhalt_flag", {31'h0, halted}, 32'h0);
        nrm();
        peek();
        cmp("resume_instr", if_instr, 32'h0022_1820);

        // Reset during stall and during redirect
        nrm(); nrm();
        drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
        peek();
        cmp("rst_stall_count", {16'h0, fetch_count}, 32'h0);
        nrm(); nrm();
        drive(1'b1, 1'b0, 1'b1, 16'h0004, 1'b1, 26'h5);
        peek();
        cmp("rst_redirect_pc", pc, 32'h0);
        cmp("rst_redirect_p4", if_pc_plus4, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 40) == 0, ($urandom % 5) == 0, ($urandom % 6) == 0,
                  16'($urandom_range(0, 24)) - 16'd12, ($urandom % 10) == 0,
                  26'($urandom_range(0, 18)));
        end
        nrm();

        repeat (3) @(posedge clk);
        #3;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
